// File: rtl/fifo.sv
// Synchronous single-clock FIFO with a registered read port and an occupancy counter.
// Reset clears the pointers, the count and data_out. Storage is not cleared; empty=1 keeps stale words unreadable.
module fifo #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              rd,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              wr_ok;
  logic              rd_ok;

  // Accept decisions use flags decoded from the registered count, so a full/empty FIFO gives priority correctly.
  assign wr_ok = wr & ~full;
  assign rd_ok = rd & ~empty;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr   <= rd_ptr + AW'(1);
        data_out <= mem[rd_ptr];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo.sv
// Directed self-checking bench for fifo: reset, fill/drain, overflow/underflow,
// simultaneous access, pointer wrap against a reference queue, and mid-operation reset.
module tb_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       empty;
  logic       full;

  int checks = 0;
  int failures = 0;

  fifo #(.DWIDTH(8), .DEPTH(16)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr       (wr),
    .rd       (rd),
    .data_in  (data_in),
    .data_out (data_out),
    .empty    (empty),
    .full     (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs are applied 1 time unit after a rising edge. Outputs are sampled 1 time unit after the next rising edge.
  task automatic op(input logic w, input logic r, input logic [7:0] d);
    wr = w;
    rd = r;
    data_in = d;
    @(posedge clk);
    #1;
    wr = 1'b0;
    rd = 1'b0;
  endtask

  logic [7:0] ref_q[$];
  logic [7:0] exp_dout;

  initial begin
    // Asynchronous reset before any clock edge
    #2 rst = 1'b0;
    #1;
    check("rst_dout", data_out, 8'h00);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);

    // A write request while reset is held is ignored
    wr = 1'b1;
    data_in = 8'h33;
    @(posedge clk);
    #1;
    wr = 1'b0;
    check("rst_wr_ignored", empty, 1'b1);
    @(negedge clk) rst = 1'b1;

    // Fill with 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      op(1'b1, 1'b0, 8'(i));
      check("fill_empty", empty, 1'b0);
      check("fill_full", full, (i == 16) ? 1'b1 : 1'b0);
    end
    op(1'b1, 1'b0, 8'hAA);
    check("ovf_full", full, 1'b1);

    // Drain: expect 0x01..0x10 in order, and no 0xAA
    for (int i = 1; i <= 16; i++) begin
      op(1'b0, 1'b1, 8'h00);
      check("drain_data", data_out, 32'(i));
      check("drain_empty", empty, (i == 16) ? 1'b1 : 1'b0);
    end
    op(1'b0, 1'b1, 8'h00);
    check("udf_dout", data_out, 8'h10);
    check("udf_empty", empty, 1'b1);

    // Read and write in the same cycle with 3 entries stored
    op(1'b1, 1'b0, 8'h11);
    op(1'b1, 1'b0, 8'h22);
    op(1'b1, 1'b0, 8'h33);
    op(1'b1, 1'b1, 8'h44);
    check("sim_mid_dout", data_out, 8'h11);
    op(1'b0, 1'b1, 8'h00);
    check("sim_mid_r1", data_out, 8'h22);
    op(1'b0, 1'b1, 8'h00);
    check("sim_mid_r2", data_out, 8'h33);
    check("sim_mid_cnt_ne", empty, 1'b0);
    op(1'b0, 1'b1, 8'h00);
    check("sim_mid_r3", data_out, 8'h44);
    check("sim_mid_cnt3", empty, 1'b1);

    // Read and write in the same cycle while empty: only the write is taken
    op(1'b1, 1'b1, 8'h55);
    check("sim_emp_dout", data_out, 8'h44);
    check("sim_emp_empty", empty, 1'b0);
    op(1'b0, 1'b1, 8'h00);
    check("sim_emp_rd", data_out, 8'h55);
    check("sim_emp_cnt1", empty, 1'b1);

    // Read and write in the same cycle while full: only the read is taken
    for (int i = 0; i < 16; i++) op(1'b1, 1'b0, 8'(8'h60 + i));
    check("sim_full_pre", full, 1'b1);
    op(1'b1, 1'b1, 8'h99);
    check("sim_full_dout", data_out, 8'h60);
    check("sim_full_nfull", full, 1'b0);
    op(1'b1, 1'b0, 8'h77);
    check("sim_full_cnt15", full, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      op(1'b0, 1'b1, 8'h00);
      check("sim_full_drain", data_out, (i == 16) ? 32'h77 : 32'(8'h60 + i));
    end
    check("sim_full_end", empty, 1'b1);

    // Random traffic; the pointers have already moved far enough that they wrap past index 15
    for (int i = 0; i < 4; i++) begin
      op(1'b1, 1'b0, 8'(8'hC0 + i));
      ref_q.push_back(8'(8'hC0 + i));
    end
    exp_dout = 8'h77;
    for (int i = 0; i < 30; i++) begin
      logic w, r, wok, rok;
      logic [7:0] d;
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      wok = w && (ref_q.size() < 16);
      rok = r && (ref_q.size() > 0);
      if (rok) exp_dout = ref_q.pop_front();
      if (wok) ref_q.push_back(d);
      op(w, r, d);
      check("wrap_dout", data_out, exp_dout);
      check("wrap_empty", empty, (ref_q.size() == 0) ? 1'b1 : 1'b0);
      check("wrap_full", full, (ref_q.size() == 16) ? 1'b1 : 1'b0);
    end
    while (ref_q.size() > 0) begin
      exp_dout = ref_q.pop_front();
      op(1'b0, 1'b1, 8'h00);
      check("wrap_drain", data_out, exp_dout);
    end
    check("wrap_end", empty, 1'b1);

    // Reset mid-operation with 5 entries stored
    for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 8'(8'hE0 + i));
    check("mid_pre", empty, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_empty", empty, 1'b1);
    check("mid_rst_dout", data_out, 8'h00);
    @(negedge clk) rst = 1'b1;
    op(1'b1, 1'b0, 8'h5A);
    op(1'b0, 1'b1, 8'h00);
    check("mid_rd", data_out, 8'h5A);
    check("mid_end", empty, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
